// File: rtl/alsu_cmd_issuer.sv
// Command issuer for an ALSU: legal commands are queued, issued one per cycle,
// and results come back tagged after the ALSU pipeline latency.
module alsu_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [15:0]              cmd_data,
  input  logic                     hold,
  output logic [15:0]              alsu_cmd,
  input  logic [5:0]               alsu_out,
  output logic                     res_valid,
  output logic [5:0]               res_data,
  output logic [1:0]               res_tag,
  output logic [7:0]               err_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic [15:0]     alsu_cmd_reg;
  logic [1:0]      tag_cnt_reg;
  logic [7:0]      err_cnt_reg;
  logic [LATENCY:0] vld_pipe_reg;
  logic [1:0]      tag_pipe_reg [LATENCY+1];
  logic            res_valid_reg;
  logic [5:0]      res_data_reg;
  logic [1:0]      res_tag_reg;

  logic [2:0] opcode;
  logic       red_any;
  logic       bypass_any;
  logic       illegal;
  logic       accept;
  logic       push;
  logic       pop;

  assign opcode     = cmd_data[9:7];
  assign red_any    = cmd_data[3] | cmd_data[2];
  assign bypass_any = cmd_data[1] | cmd_data[0];
  // opcodes 6/7 are invalid; reductions only make sense for AND/XOR
  assign illegal    = !bypass_any &&
                      ((opcode[2] && opcode[1]) || (red_any && opcode[2:1] != 2'b00));

  assign cmd_ready = (level_reg != LW'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign push      = accept && !illegal;
  // pop decision uses pre-edge occupancy, so a fresh push never issues the same edge
  assign pop       = (level_reg != '0) && !hold;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= cmd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      alsu_cmd_reg <= '0;
      tag_cnt_reg  <= '0;
      err_cnt_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        alsu_cmd_reg <= mem[rd_ptr_reg];
        tag_cnt_reg  <= tag_cnt_reg + 2'd1;
      end else begin
        alsu_cmd_reg <= 16'h0000;
      end
      level_reg <= level_reg + LW'(push) - LW'(pop);
      if (accept && illegal && err_cnt_reg != 8'hFF) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  // Stage k of the valid/tag line corresponds to k edges after issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_reg <= '0;
      for (int i = 0; i <= LATENCY; i++) begin
        tag_pipe_reg[i] <= '0;
      end
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_tag_reg   <= '0;
    end else begin
      vld_pipe_reg[0] <= pop;
      tag_pipe_reg[0] <= tag_cnt_reg;
      for (int i = 1; i <= LATENCY; i++) begin
        vld_pipe_reg[i] <= vld_pipe_reg[i-1];
        tag_pipe_reg[i] <= tag_pipe_reg[i-1];
      end
      res_valid_reg <= vld_pipe_reg[LATENCY];
      if (vld_pipe_reg[LATENCY]) begin
        res_data_reg <= alsu_out;
        res_tag_reg  <= tag_pipe_reg[LATENCY];
      end
    end
  end

  assign alsu_cmd  = alsu_cmd_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_tag   = res_tag_reg;
  assign err_cnt   = err_cnt_reg;
  assign level     = level_reg;

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Bench for alsu_cmd_issuer: stand-in ALSU plus a queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_alsu_cmd_issuer;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [15:0]   cmd_data = '0;
  logic          hold = 1'b0;
  logic [15:0]   alsu_cmd;
  logic [5:0]    alsu_out;
  logic          res_valid;
  logic [5:0]    res_data;
  logic [1:0]    res_tag;
  logic [7:0]    err_cnt;
  logic [LW-1:0] level;

  alsu_cmd_issuer #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .hold(hold), .alsu_cmd(alsu_cmd), .alsu_out(alsu_out),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
    .err_cnt(err_cnt), .level(level)
  );

  always #5 clk = ~clk;

  // Simplified ALSU behaviour, enough to give each command a distinct result.
  function automatic logic [5:0] alsu_f(input logic [15:0] c);
    logic [2:0] a, b, op;
    a  = c[15:13];
    b  = c[12:10];
    op = c[9:7];
    if (c[1]) return {3'b000, a};
    if (c[0]) return {3'b000, b};
    case (op)
      3'd0: return c[3] ? {5'b0, &a} : {3'b000, a & b};
      3'd1: return c[3] ? {5'b0, ^a} : {3'b000, a ^ b};
      3'd2: return 6'(a) + 6'(b) + 6'(c[6]);
      3'd3: return 6'(a) * 6'(b);
      3'd4: return {a, b};
      3'd5: return {b, a};
      default: return 6'd0;
    endcase
  endfunction

  logic [15:0] alsu_pipe [LATENCY];
  always @(posedge clk) begin
    alsu_pipe[0] <= alsu_cmd;
    for (int i = 1; i < LATENCY; i++) alsu_pipe[i] <= alsu_pipe[i-1];
  end
  assign alsu_out = alsu_f(alsu_pipe[LATENCY-1]);

  function automatic logic is_legal(input logic [15:0] c);
    logic [2:0] op;
    op = c[9:7];
    if (c[1] || c[0]) return 1'b1;
    if (op == 3'd6 || op == 3'd7) return 1'b0;
    if ((c[3] || c[2]) && op != 3'd0 && op != 3'd1) return 1'b0;
    return 1'b1;
  endfunction

  typedef struct {
    int         due;
    logic [5:0] data;
    logic [1:0] tag;
  } pend_t;

  logic [15:0] q[$];
  pend_t       pend[$];
  int          cyc = 0;
  int          m_err = 0;
  int          m_tag = 0;
  logic [15:0] m_cmd = '0;
  logic        m_rv = 1'b0;
  logic [5:0]  m_rd = '0;
  logic [1:0]  m_rt = '0;
  bit          verbose = 1'b0;

  int vec_cnt = 0;
  int miscmp  = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s got=%h expected=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic h, input logic r);
    logic  rdy;
    logic  pop_m;
    pend_t p;
    @(negedge clk);
    cmd_valid = v;
    cmd_data  = d;
    hold      = h;
    rst       = r;
    rdy = (q.size() != DEPTH);
    #1;
    if (!r) chk("cmd_ready_pre", 16'(cmd_ready), 16'(rdy));
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
      pend.delete();
      m_err = 0; m_tag = 0; m_cmd = '0;
      m_rv = 1'b0; m_rd = '0; m_rt = '0;
    end else begin
      pop_m = (q.size() > 0) && !h;
      m_cmd = 16'h0000;
      if (pop_m) begin
        m_cmd = q.pop_front();
        p.due = cyc + LATENCY + 1;
        p.data = alsu_f(m_cmd);
        p.tag = 2'(m_tag);
        pend.push_back(p);
        m_tag = (m_tag + 1) % 4;
      end
      if (v && rdy) begin
        if (is_legal(d)) q.push_back(d);
        else if (m_err < 255) m_err++;
      end
      m_rv = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        m_rv = 1'b1;
        m_rd = p.data;
        m_rt = p.tag;
      end
    end
    #1;
    chk("level", 16'(level), 16'(q.size()));
    chk("cmd_ready", 16'(cmd_ready), 16'(q.size() != DEPTH));
    chk("alsu_cmd", alsu_cmd, m_cmd);
    chk("res_valid", 16'(res_valid), 16'(m_rv));
    chk("res_data", 16'(res_data), 16'(m_rd));
    chk("res_tag", 16'(res_tag), 16'(m_rt));
    chk("err_cnt", 16'(err_cnt), 16'(m_err));
    if (verbose && m_rv)
      $display("result cycle=%0d data=%b tag=%0d", cyc, res_data, res_tag);
  endtask

  function automatic logic [15:0] mk(input int a, input int b, input int op, input int cin);
    return {3'(a), 3'(b), 3'(op), 1'(cin), 6'b0};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] c;
    verbose = 1'b1;
    step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    chk("reset_level", 16'(level), 16'd0);
    chk("reset_ready", 16'(cmd_ready), 16'd1);

    // ADD: 3+5+1
    c = mk(3, 5, 2, 1);
    step(1'b1, c, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("add_issue", alsu_cmd, c);
    idle(2);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("add_valid", 16'(res_valid), 16'd1);
    chk("add_data", 16'(res_data), 16'b001001);
    chk("add_tag", 16'(res_tag), 16'd0);

    // MUL back-to-back
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, mk(7, 7, 3, 0), 1'b0, 1'b0);
    step(1'b1, mk(2, 3, 3, 0), 1'b0, 1'b0);
    idle(2);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("mul0_data", 16'(res_data), 16'b110001);
    chk("mul0_tag", 16'(res_tag), 16'd0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("mul1_valid", 16'(res_valid), 16'd1);
    chk("mul1_data", 16'(res_data), 16'b000110);
    chk("mul1_tag", 16'(res_tag), 16'd1);
    idle(2);

    // Fill to full under hold, then drain
    step(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, mk(i + 1, 2, 2, 0), 1'b1, 1'b0);
    chk("full_level", 16'(level), 16'(DEPTH));
    chk("full_ready", 16'(cmd_ready), 16'd0);
    step(1'b1, mk(6, 1, 2, 0), 1'b0, 1'b0);
    step(1'b1, mk(6, 1, 2, 0), 1'b0, 1'b0);
    idle(10);

    // Illegal commands, then a bypassed opcode 6
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, mk(1, 1, 6, 0), 1'b0, 1'b0);
    step(1'b1, mk(1, 1, 2, 0) | 16'h0008, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("illegal_err", 16'(err_cnt), 16'd2);
    chk("illegal_level", 16'(level), 16'd0);
    step(1'b1, mk(5, 1, 6, 0) | 16'h0002, 1'b0, 1'b0);
    idle(5);

    // Tag wrap over six issues, then error-count saturation
    step(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, mk(i, 7 - i, 3, 0), 1'b0, 1'b0);
    idle(6);
    for (int i = 0; i < 300; i++) step(1'b1, mk(i, i, 7, 0), 1'b0, 1'b0);
    chk("err_saturate", 16'(err_cnt), 16'd255);

    // Reset with commands queued and in flight
    step(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, mk(i + 2, 3, 2, 1), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, mk(i + 4, 1, 3, 0), 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("rst_alsu_cmd", alsu_cmd, 16'h0);
    chk("rst_err", 16'(err_cnt), 16'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b0);
      chk("rst_no_valid", 16'(res_valid), 16'd0);
    end

    // Randomized traffic
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      c = 16'($urandom);
      if ($urandom_range(0, 3) != 0) c[3:0] = 4'b0000;
      step(1'($urandom_range(0, 3) != 0), c, 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 199) == 0));
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end
endmodule

// File: doc/alsu_cmd_issuer.md
ALSU_CMD_ISSUER -- requirements
Module: alsu_cmd_issuer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 Parameter LATENCY, default 2, ALSU input-to-out register latency in cycles.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  upstream command present.
REQ-006 cmd_ready  out  1  issuer can accept.
REQ-007 cmd_data  in  16  {A[15:13],B[12:10],opcode[9:7],cin[6],serial_in[5],direction[4],red_op_A[3],red_op_B[2],bypass_A[1],bypass_B[0]}.
REQ-008 hold  in  1  high = suppress issue.
REQ-009 alsu_cmd  out  16  registered command to ALSU, same layout as cmd_data.
REQ-010 alsu_out  in  6  ALSU out port.
REQ-011 res_valid  out  1  one-cycle pulse, res_data/res_tag valid.
REQ-012 res_data  out  6  captured ALSU result.
REQ-013 res_tag  out  2  issue sequence number of the result.
REQ-014 err_cnt  out  8  rejected-command count.
REQ-015 level  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-016 Handshake: transfer at rising edge when cmd_valid && cmd_ready; cmd_ready = (level != DEPTH), combinational from occupancy.
REQ-017 Illegal command: bypass_A==0 && bypass_B==0 && (opcode in {6,7} || ((red_op_A||red_op_B) && opcode not in {0,1})).
REQ-018 Illegal command: handshake completes, not written to FIFO, err_cnt += 1, saturating at 255.
REQ-019 Legal command: written to FIFO tail, level += 1.
REQ-020 Issue: each edge with level>0 and hold==0 (sampled before edge), pop head into alsu_cmd; level -= 1.
REQ-021 No issue (empty or hold==1): alsu_cmd = 16'h0000 (NOP: AND of zeros) at that edge.
REQ-022 Push and pop on the same edge: both occur, level unchanged; a command pushed into an empty FIFO issues no earlier than the following edge.
REQ-023 Full FIFO: cmd_ready low; pop on that edge raises cmd_ready only after the edge (no push-through when full).
REQ-024 Tag counter (2-bit) increments per issued command, wraps 3->0; issued tag travels with command.
REQ-025 Result pipeline: LATENCY+1-deep valid/tag shift register; command issued at edge E -> res_data <= alsu_out, res_valid=1, res_tag=tag at edge E+LATENCY+1.
REQ-026 res_valid low all other cycles; res_data/res_tag hold last captured value.
REQ-027 Sustained throughput: one issue and one result per cycle, no bubbles with hold low and FIFO non-empty.
REQ-028 hold does not affect in-flight pipeline results.

Reset
REQ-029 On rst: FIFO emptied, level=0, alsu_cmd=0, res_valid=0, res_data=0, res_tag=0, tag counter=0, err_cnt=0, pipeline valids cleared.
REQ-030 rst mid-operation: queued and in-flight commands discarded, no res_valid until a new command is issued after rst deasserts.
REQ-031 cmd_ready=1 in the first cycle after rst deasserts.

Verification
REQ-032 ADD: push A=3,B=5,opcode=2,cin=1 at edge E0 -> alsu_cmd at E1, res_valid at E4, res_data=6'b001001, res_tag=0.
REQ-033 MUL back-to-back: push A=7,B=7,op=3 then A=2,B=3,op=3 -> consecutive res_valid pulses, res_data 6'b110001 then 6'b000110, tags 0,1.
REQ-034 Fill/full: hold=1, push 5 legal commands -> 4 accepted, level=4, cmd_ready=0 on 5th; release hold -> 4 results, in order, tags 0..3, then 5th accepted.
REQ-035 Illegal: push opcode=6 (no bypass) and opcode=2 with red_op_A=1 -> err_cnt=2, level=0, no res_valid; same opcode=6 with bypass_A=1 -> accepted, result returned.
REQ-036 Tag wrap and saturation: issue 6 commands -> tags 0,1,2,3,0,1; 300 illegal pushes -> err_cnt=255.
REQ-037 Reset mid-flight: 3 queued, 2 in pipeline, assert rst 1 cycle -> all outputs 0, no res_valid for 5 cycles with no new pushes.
